// File: rtl/cache_pkg.sv
// Cache geometry shared by the miss-handling path: address split, miss descriptor
// and refill FSM state encoding.
package cache_pkg;

  localparam int unsigned ADDR_W            = 24;
  localparam int unsigned BLOCK_OFFSET_BITS = 3;
  localparam int unsigned SET_NO_BITS       = 3;
  localparam int unsigned INPUT_WAY_NO      = 4;
  localparam int unsigned MEM_DATA_W        = 8;
  localparam int unsigned TAG_W             = ADDR_W - BLOCK_OFFSET_BITS - SET_NO_BITS;
  localparam int unsigned WAY_W             = $clog2(INPUT_WAY_NO);

  typedef struct packed {
    logic [SET_NO_BITS-1:0] set;
    logic [TAG_W-1:0]       tag;
    logic [WAY_W-1:0]       way;
    logic                   write;
  } miss_desc_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StBeat,
    StInstall,
    StDone
  } refill_state_t;

  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0]       tag,
                                                   input logic [SET_NO_BITS-1:0] set);
    return {tag, set, {BLOCK_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/refill_miss_fifo.sv
// Synchronous FIFO of miss descriptors. A full FIFO refuses pushes even when it
// pops in the same cycle.
module refill_miss_fifo
  import cache_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  miss_desc_t data_i,
  input  logic       pop_i,
  output miss_desc_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

  miss_desc_t       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (push_ok && !pop_ok) begin
        count_q <= count_q + (AddrW + 1)'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - (AddrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill controller: pops one miss at a time, fetches the block beat by beat into the
// victim line, then installs {tag, valid} and pulses refill_done.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned MISSQ_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_valid,
  output logic                         miss_ready,
  input  logic [SET_NO_BITS-1:0]       miss_set,
  input  logic [TAG_W-1:0]             miss_tag,
  input  logic [WAY_W-1:0]             miss_way,
  input  logic                         miss_write,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [MEM_DATA_W-1:0]        mem_rsp_data,
  output logic                         fill_we,
  output logic [SET_NO_BITS-1:0]       fill_set,
  output logic [WAY_W-1:0]             fill_way,
  output logic [BLOCK_OFFSET_BITS-1:0] fill_offset,
  output logic [MEM_DATA_W-1:0]        fill_data,
  output logic                         tag_we,
  output logic [SET_NO_BITS-1:0]       tag_set,
  output logic [WAY_W-1:0]             tag_way,
  output logic [TAG_W:0]               tag_value,
  output logic                         refill_done,
  output logic                         busy
);

  localparam logic [BLOCK_OFFSET_BITS-1:0] LastBeat = '1;

  refill_state_t                state_q, state_d;
  logic [BLOCK_OFFSET_BITS-1:0] beat_q, beat_d;
  miss_desc_t                   act_q, act_d;
  miss_desc_t                   fifo_in, fifo_head;
  logic                         fifo_full, fifo_empty, fifo_pop;
  logic                         unused_write;

  assign fifo_in = '{set: miss_set, tag: miss_tag, way: miss_way, write: miss_write};

  refill_miss_fifo #(
    .Depth (MISSQ_DEPTH)
  ) u_missq (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (miss_valid),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    act_d         = act_q;
    fifo_pop      = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    tag_we        = 1'b0;
    refill_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          act_d    = fifo_head;
          state_d  = StReq;
        end
      end
      StReq: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = StBeat;
      end
      StBeat: begin
        if (mem_rsp_valid) begin
          fill_we = 1'b1;
          // Counter wraps to 0 on the last beat, leaving it ready for the next refill.
          beat_d  = beat_q + BLOCK_OFFSET_BITS'(1);
          if (beat_q == LastBeat) state_d = StInstall;
        end
      end
      StInstall: begin
        tag_we  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        refill_done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write-allocate fills exactly like a read miss, so the write flag is not consumed here.
  assign unused_write = act_q.write;

  assign miss_ready   = !fifo_full;
  assign busy         = !fifo_empty || (state_q != StIdle);
  assign mem_req_addr = block_addr(act_q.tag, act_q.set);
  assign fill_set     = act_q.set;
  assign fill_way     = act_q.way;
  assign fill_offset  = beat_q;
  assign fill_data    = fill_we ? mem_rsp_data : '0;
  assign tag_set      = act_q.set;
  assign tag_way      = act_q.way;
  assign tag_value    = tag_we ? {act_q.tag, 1'b1} : '0;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: behavioural memory, output monitor and
// hand-computed expectations for each refill scenario.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         miss_valid = 1'b0;
  logic                         miss_ready;
  logic [SET_NO_BITS-1:0]       miss_set = '0;
  logic [TAG_W-1:0]             miss_tag = '0;
  logic [WAY_W-1:0]             miss_way = '0;
  logic                         miss_write = 1'b0;
  logic                         mem_req_valid;
  logic                         mem_req_ready = 1'b0;
  logic [ADDR_W-1:0]            mem_req_addr;
  logic                         mem_rsp_valid = 1'b0;
  logic [MEM_DATA_W-1:0]        mem_rsp_data = '0;
  logic                         fill_we;
  logic [SET_NO_BITS-1:0]       fill_set;
  logic [WAY_W-1:0]             fill_way;
  logic [BLOCK_OFFSET_BITS-1:0] fill_offset;
  logic [MEM_DATA_W-1:0]        fill_data;
  logic                         tag_we;
  logic [SET_NO_BITS-1:0]       tag_set;
  logic [WAY_W-1:0]             tag_way;
  logic [TAG_W:0]               tag_value;
  logic                         refill_done;
  logic                         busy;

  cache_refill_ctrl #(.MISSQ_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_ready    (miss_ready),
    .miss_set      (miss_set),
    .miss_tag      (miss_tag),
    .miss_way      (miss_way),
    .miss_write    (miss_write),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .fill_we       (fill_we),
    .fill_set      (fill_set),
    .fill_way      (fill_way),
    .fill_offset   (fill_offset),
    .fill_data     (fill_data),
    .tag_we        (tag_we),
    .tag_set       (tag_set),
    .tag_way       (tag_way),
    .tag_value     (tag_value),
    .refill_done   (refill_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Memory model configuration, written only by the stimulus process.
  int        stall_len = 0;
  int        gap_at    = -1;
  int        gap_len   = 0;
  logic [7:0] data_base = 8'h00;
  bit        stray     = 1'b0;

  // Memory model state, owned by the model process.
  bit streaming = 1'b0, pending = 1'b0, prev_req = 1'b0;
  int beat_idx = 0, stall_left = 0, gap_left = 0;

  always @(negedge clk) begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (rst) begin
      streaming = 1'b0;
      pending   = 1'b0;
      prev_req  = 1'b0;
    end else begin
      if (pending) begin
        pending   = 1'b0;
        streaming = 1'b1;
        beat_idx  = 0;
        gap_left  = gap_len;
      end
      if (stray) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 8'hEE;
      end else if (streaming) begin
        if (beat_idx == gap_at && gap_left > 0) begin
          gap_left--;
        end else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = data_base + 8'(beat_idx);
          beat_idx++;
          if (beat_idx == 8) streaming = 1'b0;
        end
      end
      if (mem_req_valid) begin
        if (!prev_req) stall_left = stall_len;
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          pending       = 1'b1;
        end
      end
      prev_req = mem_req_valid;
    end
  end

  // Monitor: {set, way, offset, data} per fill, {set, way, tag_value} per install.
  logic [15:0] fill_q[$];
  logic [23:0] tag_q[$];
  int          tag_fills_q[$];
  logic [23:0] addr_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    #2;
    if (fill_we) fill_q.push_back({fill_set, fill_way, fill_offset, fill_data});
    if (tag_we) begin
      tag_q.push_back({tag_set, tag_way, tag_value});
      tag_fills_q.push_back(fill_q.size());
    end
    if (refill_done) done_cnt++;
    if (mem_req_valid) addr_q.push_back(mem_req_addr);
  end

  task automatic clear_logs();
    fill_q.delete();
    tag_q.delete();
    tag_fills_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic push(input logic [17:0] tg, input logic [2:0] st, input logic [1:0] wy,
                      input logic wr);
    miss_valid = 1'b1;
    miss_tag   = tg;
    miss_set   = st;
    miss_way   = wy;
    miss_write = wr;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int lat);
    bit seen = 1'b0;
    lat = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      #3;
      lat++;
      seen = refill_done;
    end
    if (!seen) check_eq({nm, ".timeout"}, 64'd0, 64'd1);
  endtask

  task automatic verify_refill(input string nm, input logic [17:0] tg, input logic [2:0] st,
                               input logic [1:0] wy, input logic [7:0] base, input int n_req);
    logic [23:0] ea;
    int          bad;
    ea  = {tg, st, 3'b000};
    bad = 0;
    check_eq({nm, ".req_cycles"}, 64'(addr_q.size()), 64'(n_req));
    foreach (addr_q[i]) if (addr_q[i] !== ea) bad++;
    check_eq({nm, ".req_addr_bad"}, 64'(bad), 64'd0);
    check_eq({nm, ".fill_count"}, 64'(fill_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < fill_q.size()) begin
        check_eq($sformatf("%s.fill%0d", nm, i), 64'(fill_q[i]),
                 64'({st, wy, 3'(i), base + 8'(i)}));
      end
    end
    check_eq({nm, ".tag_count"}, 64'(tag_q.size()), 64'd1);
    if (tag_q.size() >= 1) begin
      check_eq({nm, ".tag_value"}, 64'(tag_q[0]), 64'({st, wy, tg, 1'b1}));
      check_eq({nm, ".tag_after_fills"}, 64'(tag_fills_q[0]), 64'd8);
    end
  endtask

  task automatic run_refill(input string nm, input logic [17:0] tg, input logic [2:0] st,
                            input logic [1:0] wy, input logic wr, input logic [7:0] base,
                            input int exp_lat);
    int lat;
    clear_logs();
    data_base = base;
    push(tg, st, wy, wr);
    wait_done(nm, lat);
    check_eq({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    verify_refill(nm, tg, st, wy, base, 1 + stall_len);
    @(negedge clk);
    #3;
    check_eq({nm, ".idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int guard;
    bit hit;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3;
    check_eq("rst.miss_ready", 64'(miss_ready), 64'd1);
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_eq("rst.mem_req_addr", 64'(mem_req_addr), 64'd0);
    check_eq("rst.fill_we", 64'(fill_we), 64'd0);
    check_eq("rst.tag_we", 64'(tag_we), 64'd0);
    check_eq("rst.tag_value", 64'(tag_value), 64'd0);
    check_eq("rst.refill_done", 64'(refill_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #3;

    // Basic read miss; address from the test plan is hard-coded
    clear_logs();
    data_base = 8'h10;
    push(18'h2ABCD, 3'd5, 2'd2, 1'b0);
    wait_done("read", lat);
    check_eq("read.latency", 64'(lat), 64'd12);
    check_eq("read.addr_const", 64'(addr_q.size() > 0 ? addr_q[0] : 24'h0), 64'h00AAF368);
    verify_refill("read", 18'h2ABCD, 3'd5, 2'd2, 8'h10, 1);

    // Memory request stalled for 5 cycles
    stall_len = 5;
    run_refill("stall", 18'h01234, 3'd3, 2'd1, 1'b0, 8'h40, 17);
    stall_len = 0;

    // Two-cycle gap between beats 3 and 4
    gap_at  = 4;
    gap_len = 2;
    run_refill("gap", 18'h3C3C3, 3'd6, 2'd3, 1'b0, 8'hA0, 14);
    gap_at  = -1;
    gap_len = 0;

    // Write miss behaves like a read miss
    run_refill("write", 18'h15555, 3'd0, 2'd0, 1'b1, 8'hC8, 12);

    // Stray response beats while idle
    clear_logs();
    stray = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    stray = 1'b0;
    @(negedge clk);
    #3;
    check_eq("stray.fill_count", 64'(fill_q.size()), 64'd0);
    check_eq("stray.busy", 64'(busy), 64'd0);

    // Three back-to-back pushes into a 2-deep FIFO
    clear_logs();
    data_base = 8'h20;
    push(18'h00001, 3'd1, 2'd0, 1'b0);
    push(18'h3FFFF, 3'd7, 2'd3, 1'b0);
    push(18'h12345, 3'd2, 2'd1, 1'b1);
    @(negedge clk);
    #3;
    check_eq("b2b.miss_ready_full", 64'(miss_ready), 64'd0);
    check_eq("b2b.busy", 64'(busy), 64'd1);
    guard = 0;
    while (done_cnt < 3 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    #3;
    check_eq("b2b.done_count", 64'(done_cnt), 64'd3);
    check_eq("b2b.tag_count", 64'(tag_q.size()), 64'd3);
    check_eq("b2b.fill_count", 64'(fill_q.size()), 64'd24);
    if (tag_q.size() == 3) begin
      check_eq("b2b.tag0", 64'(tag_q[0]), 64'({3'd1, 2'd0, 18'h00001, 1'b1}));
      check_eq("b2b.tag1", 64'(tag_q[1]), 64'({3'd7, 2'd3, 18'h3FFFF, 1'b1}));
      check_eq("b2b.tag2", 64'(tag_q[2]), 64'({3'd2, 2'd1, 18'h12345, 1'b1}));
      check_eq("b2b.tag1_after_fills", 64'(tag_fills_q[1]), 64'd16);
    end
    if (fill_q.size() == 24) begin
      check_eq("b2b.fill8", 64'(fill_q[8]), 64'({3'd7, 2'd3, 3'd0, 8'h20}));
      check_eq("b2b.fill23", 64'(fill_q[23]), 64'({3'd2, 2'd1, 3'd7, 8'h27}));
    end
    @(negedge clk);
    #3;
    check_eq("b2b.idle_after", 64'(busy), 64'd0);
    check_eq("b2b.miss_ready_after", 64'(miss_ready), 64'd1);

    // Reset during beat 5 abandons the refill
    clear_logs();
    data_base = 8'h60;
    push(18'h0BEEF, 3'd4, 2'd2, 1'b0);
    guard = 0;
    hit   = 1'b0;
    while (!hit && guard < 100) begin
      @(negedge clk);
      #3;
      guard++;
      hit = fill_we && (fill_offset == 3'd5);
    end
    check_eq("rstmid.reached_beat5", 64'(hit), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #3;
    check_eq("rstmid.busy", 64'(busy), 64'd0);
    check_eq("rstmid.miss_ready", 64'(miss_ready), 64'd1);
    check_eq("rstmid.mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_eq("rstmid.fill_we", 64'(fill_we), 64'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #3;
    check_eq("rstmid.no_tag_we", 64'(tag_q.size()), 64'd0);
    check_eq("rstmid.no_done", 64'(done_cnt), 64'd0);
    check_eq("rstmid.still_idle", 64'(busy), 64'd0);

    // Normal refill after the abandoned one
    run_refill("post_rst", 18'h2ABCD, 3'd5, 2'd2, 1'b0, 8'h10, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling stage directly downstream of the set-associative LRU cache lookup/replacement block.
- Accepts miss descriptors (set, tag, victim way, read/write) through a small FIFO, fetches the whole block from memory beat by beat, and writes each beat into the victim line.
- Installs the tag with the valid bit set only after the last beat, then pulses refill_done so the lookup stage can resume.
- Write misses are write-allocate: same fill sequence as read misses.

Parameters:
- ADDR_W, 24: request address width.
- BLOCK_OFFSET_BITS, 3: log2 of bytes per block; beats per refill = 2**BLOCK_OFFSET_BITS.
- SET_NO_BITS, 3: log2 of the number of sets.
- INPUT_WAY_NO, 4: associativity; WAY_W = clog2(INPUT_WAY_NO).
- MEM_DATA_W, 8: bits per memory beat (one byte).
- MISSQ_DEPTH, 2: miss FIFO entries (power of 2).
- Derived: TAG_W = ADDR_W - BLOCK_OFFSET_BITS - SET_NO_BITS (18 at defaults).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- miss_valid  in  1  a miss descriptor is offered.
- miss_ready  out  1  the FIFO can accept a descriptor.
- miss_set  in  SET_NO_BITS  set index of the miss.
- miss_tag  in  TAG_W  incoming tag.
- miss_way  in  WAY_W  victim way chosen by LRU.
- miss_write  in  1  1 = write miss, 0 = read miss.
- mem_req_valid  out  1  block read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  block-aligned address {tag, set, offset=0}.
- mem_rsp_valid  in  1  response beat valid.
- mem_rsp_data  in  MEM_DATA_W  response beat data.
- fill_we  out  1  data-array write enable.
- fill_set  out  SET_NO_BITS  data-array set index.
- fill_way  out  WAY_W  data-array way.
- fill_offset  out  BLOCK_OFFSET_BITS  byte offset within the block.
- fill_data  out  MEM_DATA_W  byte written to the data array.
- tag_we  out  1  tag/valid overhead write enable.
- tag_set  out  SET_NO_BITS  overhead set index.
- tag_way  out  WAY_W  overhead way.
- tag_value  out  TAG_W+1  {tag, valid=1}; valid is the LSB, matching the overhead layout.
- refill_done  out  1  one-cycle pulse when the line is installed.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset: FIFO emptied, FSM goes to IDLE, beat counter = 0. All outputs are 0 except miss_ready = 1.
- Miss FIFO:
  - Push on miss_valid && miss_ready.
  - miss_ready = !full. A full FIFO accepts no push, even if it pops in the same cycle.
  - Simultaneous push and pop when not full: both take effect; count is unchanged.
- FSM states: IDLE, REQ, BEAT, INSTALL, DONE.
  - IDLE: if the FIFO is non-empty, pop the head into the active registers (set, tag, way, write) and go to REQ. A descriptor pushed into an empty FIFO at edge N is popped at edge N+1.
  - REQ: mem_req_valid = 1 and mem_req_addr is held stable until mem_req_ready; on the handshake go to BEAT.
  - BEAT:
    - fill_we = mem_rsp_valid (combinational).
    - fill_offset = beat counter; fill_data = mem_rsp_data; fill_set/fill_way = active registers.
    - Counter increments per valid beat. On the beat where the counter equals 2**BLOCK_OFFSET_BITS-1, go to INSTALL and clear the counter.
    - Gaps between beats are allowed.
  - INSTALL: tag_we = 1 for exactly one cycle, with tag_value = {active tag, 1'b1}. Go to DONE.
  - DONE: refill_done = 1 for one cycle; return to IDLE.
- Ordering: the valid bit is never written before every data beat has been written.
- Minimum latency, push to refill_done with mem_req_ready = 1 and beats back-to-back: 1 (IDLE) + 1 (REQ) + 8 (BEAT) + 1 (INSTALL) + 1 (DONE) = 12 cycles.
- Only one refill is in flight. Later FIFO entries wait; there is no merging of duplicate misses.
- mem_rsp_valid outside BEAT is ignored; fill_we stays 0.
- Reset mid-operation: the refill is abandoned with no tag_we and no refill_done. The partial data-array contents are harmless because the line stays invalid.
- The beat counter is BLOCK_OFFSET_BITS wide and wraps to 0 naturally after the last beat.

Decomposition:
- Shared package cache_pkg holds the cache geometry:
  - constants: ADDR_W, BLOCK_OFFSET_BITS, SET_NO_BITS, INPUT_WAY_NO, TAG_W, WAY_W;
  - typedef miss_desc_t {set, tag, way, write};
  - enum refill_state_t.
- One sub-module: refill_miss_fifo, a parameterised synchronous FIFO of miss_desc_t with full/empty flags.

Test Plan:
- Read miss, tag=18'h2ABCD, set=5, way=2, beats 8'h10..8'h17 back-to-back -> mem_req_addr=24'hAAF368; fill_we for offsets 0..7 with data 8'h10..8'h17; tag_we with tag_value={18'h2ABCD,1'b1}; refill_done 12 cycles after the push.
- mem_req_ready held low 5 cycles -> mem_req_valid stays high with a stable address; no fill_we; total latency 17 cycles.
- Push 3 misses back-to-back with depth 2 -> miss_ready drops after the FIFO fills (first pop at N+1 makes room for the third, so check at a full FIFO); refills complete in push order with 3 refill_done pulses.
- 2-cycle gap between beats 3 and 4 -> fill_offset continues at 4 with no skip and no duplicate; refill_done is delayed by 2 cycles.
- rst asserted during beat 5 -> the next cycle shows IDLE, busy=0, miss_ready=1, no tag_we, no refill_done; a subsequent miss refills normally.
- Write miss (miss_write=1) -> fill and install sequence identical to a read miss; stray mem_rsp_valid in IDLE produces no fill_we.
